fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameters, one per line: name, default, meaning.
  NUM_REQ  4  number of requesters, range 2..8
  ID_WIDTH  2  tag width, SHALL satisfy 2^ID_WIDTH >= NUM_REQ
  DATA_WIDTH  64  payload width per requester
  ADDR_WIDTH  4  address width of the downstream fifo; RAM_DEPTH = 2^ADDR_WIDTH
  BURST_LEN  4  maximum consecutive beats per grant, range 1..16
REQ-002 Ports, one per line: name, direction, width, meaning.
  clk  in  1  single clock, rising edge
  rst_n  in  1  reset, synchronous, active-low
  req  in  NUM_REQ  per-requester push request; held with data until granted
  req_data  in  NUM_REQ*DATA_WIDTH  payload of requester i in slice i
  gnt  out  NUM_REQ  one-hot combinational accept; beat transfers in any cycle where req[i]&gnt[i]
  fifo_push  out  1  registered push to downstream fifo
  fifo_data  out  ID_WIDTH+DATA_WIDTH  registered {requester id, payload}
  fifo_count  in  ADDR_WIDTH+1  occupancy reported by downstream fifo
  stat_gnt_cnt  out  NUM_REQ*16  per-requester beat counters (see Configuration)

Function
REQ-003 At most one gnt bit SHALL be high per cycle; gnt[i] SHALL never be high while req[i] is low.
REQ-004 Space check: grant allowed only when fifo_count + fifo_push < RAM_DEPTH; otherwise gnt = 0 (stall), state, owner and pointers unchanged.
REQ-005 Latency: beat accepted in cycle N SHALL appear as fifo_push=1 with fifo_data={id,payload} in cycle N+1; fifo_push SHALL be 0 in any cycle following a cycle without a grant.
REQ-006 FSM states IDLE and BURST; reset state IDLE.
REQ-007 IDLE: round-robin search of req starting at pointer rr_ptr (wrapping NUM_REQ-1 -> 0); the first requesting index i is granted if space allows; if BURST_LEN>1, next state BURST, owner=i, beat_cnt=1.
REQ-008 BURST: only the owner may be granted; each granted beat increments beat_cnt; return to IDLE after the beat making beat_cnt == BURST_LEN, or in the first cycle the owner's req is low (no grant that cycle).
REQ-009 On each transition into IDLE (and every grant when BURST_LEN == 1) rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-010 Stall in BURST (no space) SHALL neither release ownership nor count a beat.
REQ-011 Requests from non-owners during BURST SHALL be ignored, not queued.

Reset
REQ-012 With rst_n low at a rising edge: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, fifo_push=0, fifo_data=0, stat_gnt_cnt=0.
REQ-013 gnt SHALL be 0 in every cycle rst_n is low.
REQ-014 Reset asserted mid-burst SHALL abandon the burst; a beat granted in the cycle before reset SHALL NOT be pushed after reset.

Configuration
REQ-015 Macro FIFO_WR_ARB_STAT_EN defined: stat_gnt_cnt slice i increments by 1 per granted beat of requester i, saturating at 0xFFFF.
REQ-016 Macro not defined: stat_gnt_cnt tied to 0, counter logic absent; all other behaviour identical.

Verification
REQ-017 Default parameters, req=4'b1111 continuously, fifo_count=0 -> bursts of 4 beats in order ids 0,1,2,3,0; fifo_push continuous from cycle 2.
REQ-018 fifo_count=15, fifo_push=0, req[2]=1 -> one grant; next cycle gnt=0 (15+1=16); push appears with id 2.
REQ-019 Owner 1 drops req after 2 beats while req[3]=1 -> BURST exits without grant that cycle, rr_ptr=2, requester 3 granted next cycle.
REQ-020 BURST_LEN=1, req=4'b0101 -> gnt alternates 0001,0100,0001.
REQ-021 rst_n low for one cycle during beat 2 of a burst -> fifo_push=0 next cycle, state IDLE, first post-reset grant to lowest requesting index from 0.
REQ-022 With FIFO_WR_ARB_STAT_EN, 70000 beats from requester 0 -> stat_gnt_cnt[15:0]=0xFFFF; without the macro it stays 0.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter that pushes {requester id, payload} beats into a downstream fifo.
// Define FIFO_WR_ARB_STAT_EN to build the per-requester saturating beat counters.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ID_WIDTH   = 2,
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 4,
  parameter int BURST_LEN  = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic                           fifo_push,
  output logic [ID_WIDTH+DATA_WIDTH-1:0] fifo_data,
  input  logic [ADDR_WIDTH:0]            fifo_count,
  output logic [NUM_REQ*16-1:0]          stat_gnt_cnt
);

  localparam int RAM_DEPTH = 1 << ADDR_WIDTH;
  localparam int CW        = 5;

  typedef enum logic {IDLE, BURST} state_t;

  state_t                  state;
  logic [ID_WIDTH-1:0]     rr_ptr;
  logic [ID_WIDTH-1:0]     owner;
  logic [ID_WIDTH-1:0]     grant_id;
  logic [CW-1:0]           beat_cnt;
  logic [ADDR_WIDTH+1:0]   occupancy;
  logic                    space_ok;
  logic                    owner_req;
  logic                    search_hit;
  logic                    grant_valid;
  logic                    burst_last;
  logic [DATA_WIDTH-1:0]   grant_payload;

  function automatic logic [ID_WIDTH-1:0] wrap_inc(input logic [ID_WIDTH-1:0] p);
    return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
  endfunction

  // The beat registered last cycle is not yet in fifo_count, so it is counted here.
  assign occupancy  = {1'b0, fifo_count} + {{(ADDR_WIDTH+1){1'b0}}, fifo_push};
  assign space_ok   = occupancy < (ADDR_WIDTH+2)'(RAM_DEPTH);
  assign burst_last = (beat_cnt == CW'(BURST_LEN - 1));

  always_comb begin
    owner_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++)
      if (int'(owner) == i) owner_req = req[i];
  end

  always_comb begin
    search_hit = 1'b0;
    grant_id   = owner;
    if (state == IDLE) begin
      for (int k = 0; k < NUM_REQ; k++)
        for (int i = 0; i < NUM_REQ; i++)
          if (!search_hit && req[i] && ((int'(rr_ptr) + k) % NUM_REQ) == i) begin
            search_hit = 1'b1;
            grant_id   = ID_WIDTH'(i);
          end
    end
    grant_valid = rst_n && space_ok && ((state == IDLE) ? search_hit : owner_req);
  end

  always_comb begin
    gnt           = '0;
    grant_payload = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (int'(grant_id) == i) begin
        gnt[i]        = grant_valid;
        grant_payload = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  // A full fifo freezes everything in BURST, including a pending release by a dropped request.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      beat_cnt  <= '0;
      fifo_push <= 1'b0;
      fifo_data <= '0;
    end else begin
      fifo_push <= grant_valid;
      if (grant_valid) fifo_data <= {grant_id, grant_payload};
      case (state)
        IDLE: begin
          if (grant_valid) begin
            if (BURST_LEN == 1) begin
              rr_ptr <= wrap_inc(grant_id);
            end else begin
              state    <= BURST;
              owner    <= grant_id;
              beat_cnt <= CW'(1);
            end
          end
        end
        BURST: begin
          if (space_ok) begin
            if (!owner_req) begin
              state  <= IDLE;
              rr_ptr <= wrap_inc(owner);
            end else begin
              beat_cnt <= beat_cnt + 1'b1;
              if (burst_last) begin
                state  <= IDLE;
                rr_ptr <= wrap_inc(owner);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STAT_EN
  logic [15:0] stat_cnt [NUM_REQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) stat_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++)
        if (gnt[i] && stat_cnt[i] != 16'hFFFF) stat_cnt[i] <= stat_cnt[i] + 16'd1;
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_gnt_cnt[g*16 +: 16] = stat_cnt[g];
  end
`else
  assign stat_gnt_cnt = '0;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Randomized and directed bench for fifo_wr_arbiter against a queue-free behavioural model.
// Expected statistics follow FIFO_WR_ARB_STAT_EN in the same way as the design.
module tb_fifo_wr_arbiter;

  localparam int N = 4, IW = 2, DW = 64, AW = 4, BL = 4, DEPTH = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      gnt;
  logic              fifo_push;
  logic [IW+DW-1:0]  fifo_data;
  logic [AW:0]       fifo_count;
  logic [N*16-1:0]   stat_gnt_cnt;
  logic [N-1:0]      gnt1;
  logic              push1;
  logic [IW+DW-1:0]  data1;
  logic [N*16-1:0]   stat1;

  int compared   = 0;
  int mismatched = 0;

  bit               m_busy;
  int               m_owner, m_beats, m_ptr;
  bit               m_push;
  logic [IW+DW-1:0] m_data;
  int               m_stat [N];
  logic [N-1:0]     last_g;

  fifo_wr_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt),
    .fifo_push(fifo_push), .fifo_data(fifo_data), .fifo_count(fifo_count), .stat_gnt_cnt(stat_gnt_cnt)
  );

  fifo_wr_arbiter #(.NUM_REQ(N), .ID_WIDTH(IW), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data), .gnt(gnt1),
    .fifo_push(push1), .fifo_data(data1), .fifo_count(fifo_count), .stat_gnt_cnt(stat1)
  );

  always #5 clk = ~clk;

  function automatic logic [N-1:0] model_gnt();
    int c;
    if (!rst_n) return '0;
    if (int'(fifo_count) + int'(m_push) >= DEPTH) return '0;
    if (m_busy) return ((req >> m_owner) & N'(1)) != 0 ? (N'(1) << m_owner) : '0;
    for (int k = 0; k < N; k++) begin
      c = (m_ptr + k) % N;
      if (((req >> c) & N'(1)) != 0) return N'(1) << c;
    end
    return '0;
  endfunction

  task automatic model_step(input logic [N-1:0] g, input logic [N*DW-1:0] d, input logic [AW:0] cnt, input logic rn);
    int id;
    bit space;
    if (!rn) begin
      m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_push = 0; m_data = '0;
      foreach (m_stat[i]) m_stat[i] = 0;
      return;
    end
    space  = (int'(cnt) + int'(m_push)) < DEPTH;
    m_push = (g != 0);
    id     = $clog2(g);
    if (g != 0) begin
      m_data = {IW'(id), d[id*DW +: DW]};
      if (m_stat[id] < 65535) m_stat[id]++;
    end
    if (g != 0 && !m_busy) begin
      if (BL == 1) m_ptr = (id + 1) % N;
      else begin m_busy = 1; m_owner = id; m_beats = 1; end
    end else if (m_busy && space) begin
      if (g == 0) begin
        m_busy = 0; m_ptr = (m_owner + 1) % N;
      end else begin
        m_beats++;
        if (m_beats == BL) begin m_busy = 0; m_ptr = (m_owner + 1) % N; end
      end
    end
  endtask

  // One clock: check combinational grant, advance the model on the edge, check registered push.
  task automatic tick();
    logic [N-1:0]    g;
    logic [N*DW-1:0] d;
    logic [AW:0]     c;
    logic            rn;
    #1;
    g = model_gnt();
    compared++;
    if (gnt !== g) begin
      mismatched++;
      $display("[TB] FAIL gnt: got %b expected %b at %0t", gnt, g, $time);
    end
    d = req_data; c = fifo_count; rn = rst_n;
    last_g = g;
    @(posedge clk);
    model_step(g, d, c, rn);
    #1;
    compared++;
    if (fifo_push !== m_push) begin
      mismatched++;
      $display("[TB] FAIL fifo_push: got %b expected %b at %0t", fifo_push, m_push, $time);
    end
    compared++;
    if (fifo_data !== m_data) begin
      mismatched++;
      $display("[TB] FAIL fifo_data: got %h expected %h at %0t", fifo_data, m_data, $time);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic randomize_data();
    for (int i = 0; i < N; i++) req_data[i*DW +: DW] = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    req = '1; fifo_count = '0; randomize_data();
    do_reset();
    compared++;
    if (fifo_push !== 1'b0 || fifo_data !== '0 || stat_gnt_cnt !== '0) begin
      mismatched++;
      $display("[TB] FAIL reset_state: push=%b data=%h stat=%h expected 0/0/0", fifo_push, fifo_data, stat_gnt_cnt);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    req = 4'b1111; fifo_count = '0;
    for (int c = 0; c < 20; c++) begin
      randomize_data();
      tick();
      compared++;
      if (fifo_push !== 1'b1 || fifo_data[IW+DW-1:DW] !== IW'((c / 4) % 4)) begin
        mismatched++;
        $display("[TB] FAIL rr_order beat %0d: push=%b id=%0d expected 1/%0d", c, fifo_push, fifo_data[IW+DW-1:DW], (c / 4) % 4);
      end
    end
  endtask

  task automatic test_fifo_full();
    do_reset();
    req = 4'b0100; fifo_count = 5'd15; randomize_data();
    for (int c = 0; c < 4; c++) begin
      tick();
      compared++;
      if (fifo_push !== ((c % 2) == 0) || (fifo_push && fifo_data[IW+DW-1:DW] !== 2'd2)) begin
        mismatched++;
        $display("[TB] FAIL near_full %0d: push=%b id=%0d expected %0d/2", c, fifo_push, fifo_data[IW+DW-1:DW], (c % 2) == 0);
      end
    end
    fifo_count = 5'd16;
    tick();
    compared++;
    if (fifo_push !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL full_stall: push=%b expected 0", fifo_push);
    end
  endtask

  task automatic test_owner_drop();
    do_reset();
    req = 4'b1010; fifo_count = '0; randomize_data();
    tick();
    tick();
    req = 4'b1000;
    tick();
    compared++;
    if (fifo_push !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL drop_exit: push=%b expected 0", fifo_push);
    end
    tick();
    compared++;
    if (fifo_push !== 1'b1 || fifo_data[IW+DW-1:DW] !== 2'd3) begin
      mismatched++;
      $display("[TB] FAIL drop_next: push=%b id=%0d expected 1/3", fifo_push, fifo_data[IW+DW-1:DW]);
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    req = 4'b1111; fifo_count = '0; randomize_data();
    tick();
    rst_n = 1'b0;
    tick();
    compared++;
    if (fifo_push !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset_push: push=%b expected 0", fifo_push);
    end
    rst_n = 1'b1;
    req = 4'b0110;
    tick();
    compared++;
    if (fifo_push !== 1'b1 || fifo_data[IW+DW-1:DW] !== 2'd1) begin
      mismatched++;
      $display("[TB] FAIL post_reset_grant: push=%b id=%0d expected 1/1", fifo_push, fifo_data[IW+DW-1:DW]);
    end
  endtask

  task automatic test_burst_len1();
    logic [IW-1:0] exp_ids [3];
    exp_ids = '{2'd0, 2'd2, 2'd0};
    do_reset();
    req = 4'b0101; fifo_count = '0; randomize_data();
    for (int c = 0; c < 3; c++) begin
      tick();
      compared++;
      if (push1 !== 1'b1 || data1 !== {exp_ids[c], req_data[int'(exp_ids[c])*DW +: DW]}) begin
        mismatched++;
        $display("[TB] FAIL bl1_seq %0d: push=%b data=%h expected id %0d", c, push1, data1, exp_ids[c]);
      end
    end
  endtask

  task automatic test_random();
    int exp_stat;
    do_reset();
    req = '0; fifo_count = '0;
    for (int c = 0; c < 400; c++) begin
      fifo_count = AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) fifo_count = 5'd16;
      tick();
      req = req & ~last_g;
      for (int i = 0; i < N; i++) begin
        if (req[i] && $urandom_range(0, 15) == 0) req[i] = 1'b0;
        else if (!req[i] && $urandom_range(0, 1) == 1) begin
          req[i] = 1'b1;
          req_data[i*DW +: DW] = {$urandom, $urandom};
        end
      end
    end
    for (int i = 0; i < N; i++) begin
`ifdef FIFO_WR_ARB_STAT_EN
      exp_stat = m_stat[i];
`else
      exp_stat = 0;
`endif
      compared++;
      if (stat_gnt_cnt[i*16 +: 16] !== 16'(exp_stat)) begin
        mismatched++;
        $display("[TB] FAIL stat_random[%0d]: got %0d expected %0d", i, stat_gnt_cnt[i*16 +: 16], exp_stat);
      end
    end
  endtask

  task automatic test_stat_saturation();
    int beats;
    logic [15:0] exp_cnt;
`ifdef FIFO_WR_ARB_STAT_EN
    beats   = 70000;
    exp_cnt = 16'hFFFF;
`else
    beats   = 300;
    exp_cnt = 16'h0000;
`endif
    do_reset();
    req = 4'b0001; fifo_count = '0; randomize_data();
    for (int c = 0; c < beats; c++) tick();
    compared++;
    if (stat_gnt_cnt[15:0] !== exp_cnt) begin
      mismatched++;
      $display("[TB] FAIL stat_sat: got %h expected %h", stat_gnt_cnt[15:0], exp_cnt);
    end
    compared++;
    if (stat_gnt_cnt[N*16-1:16] !== '0) begin
      mismatched++;
      $display("[TB] FAIL stat_others: got %h expected 0", stat_gnt_cnt[N*16-1:16]);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; fifo_count = '0; last_g = '0;
    m_busy = 0; m_owner = 0; m_beats = 0; m_ptr = 0; m_push = 0; m_data = '0;
    foreach (m_stat[i]) m_stat[i] = 0;
    test_reset();
    test_round_robin();
    test_fifo_full();
    test_owner_drop();
    test_reset_mid_burst();
    test_burst_len1();
    test_random();
    test_stat_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
